// File: rtl/key_evt_pkg.sv
// Shared key-handling definitions: gesture decoder state encoding and
// 5 MHz timing defaults for the key path (debouncer and event decoder).
package key_evt_pkg;

  localparam int unsigned CLK_HZ          = 5_000_000;
  localparam int unsigned DEB_CYC         = 100_000;    // debouncer settle time, 20 ms
  localparam int unsigned KEY_LONG_CYC    = 5_000_000;  // 1 s
  localparam int unsigned KEY_DBL_GAP_CYC = 1_250_000;  // 250 ms

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HOLD
  } key_state_e;

endpackage

// File: rtl/key_event_decoder.sv
// Classifies debounced active-low key gestures into click / double click /
// long press strobes, with a held level and a wrapping event counter.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int unsigned LONG_CYC    = KEY_LONG_CYC,
  parameter int unsigned DBL_GAP_CYC = KEY_DBL_GAP_CYC,
  parameter int unsigned CNT_W       = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       click,
  output logic       dbl_click,
  output logic       long_press,
  output logic       held,
  output logic [7:0] evt_cnt
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);

  key_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic             click_d, dbl_d, long_d, held_d;
  logic [7:0]       evt_d;

  // Saturating increment; thresholds exit first, so saturation is only a guard.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    click_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    case (state)
      ARM: begin
        if (key_n) state_d = IDLE;
      end
      IDLE: begin
        if (!key_n) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        // Release is tested first so it wins over a coincident long-press threshold.
        if (key_n) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LONG_HOLD: begin
        if (key_n) state_d = IDLE;
      end
      WAIT2: begin
        // A second press wins over a coincident gap timeout.
        if (!key_n) begin
          state_d = PRESS2;
        end else if (cnt == GAP_LAST) begin
          click_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESS2: begin
        if (key_n) begin
          dbl_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = ARM;
    endcase
    held_d = (state_d == LONG_HOLD);
    evt_d  = evt_cnt + 8'(click_d | dbl_d | long_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARM;
      cnt        <= '0;
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
      held       <= 1'b0;
      evt_cnt    <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      click      <= click_d;
      dbl_click  <= dbl_d;
      long_press <= long_d;
      held       <= held_d;
      evt_cnt    <= evt_d;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: expected strobes are queued with their
// due edge as stimulus is driven and matched by a negedge monitor.
module tb_key_event_decoder;

  localparam int unsigned T_LONG = 20;
  localparam int unsigned T_GAP  = 8;

  localparam int K_CLICK = 1;
  localparam int K_DBL   = 2;
  localparam int K_LONG  = 3;

  typedef struct {
    int kind;
    int at_edge;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic       click, dbl_click, long_press, held;
  logic [7:0] evt_cnt;

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  exp_t sb[$];
  exp_t front;
  int   kind_o;
  int   nstb;

  key_event_decoder #(
    .LONG_CYC   (T_LONG),
    .DBL_GAP_CYC(T_GAP),
    .CNT_W      (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .click     (click),
    .dbl_click (dbl_click),
    .long_press(long_press),
    .held      (held),
    .evt_cnt   (evt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Key level v is sampled by the next n rising edges; returns #1 after the last.
  task automatic drive(input logic v, input int n);
    key_n = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int kind, input int at_edge);
    exp_t e;
    e.kind    = kind;
    e.at_edge = at_edge;
    sb.push_back(e);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_click"}, int'(click), 0);
    check({tag, "_dbl"}, int'(dbl_click), 0);
    check({tag, "_long"}, int'(long_press), 0);
    check({tag, "_held"}, int'(held), 0);
    check({tag, "_evt_cnt"}, int'(evt_cnt), 0);
  endtask

  // Scoreboard monitor: every strobe must match the queue head at its due edge.
  always @(negedge clk) begin
    nstb = int'(click) + int'(dbl_click) + int'(long_press);
    if (nstb != 0) begin
      kind_o = click ? K_CLICK : (dbl_click ? K_DBL : K_LONG);
      check("strobe_onehot", nstb, 1);
      if (sb.size() == 0) begin
        check("unexpected_evt", kind_o, 0);
      end else begin
        front = sb.pop_front();
        check("evt_kind", kind_o, front.kind);
        check("evt_edge", edge_n, front.at_edge);
      end
    end else if (sb.size() != 0 && sb[0].at_edge <= edge_n) begin
      front = sb.pop_front();
      check("missing_evt", 0, front.kind);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    key_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    drive(1'b1, 3);

    // Single click: strobe 8 edges after release is sampled
    drive(1'b0, 5);
    expect_evt(K_CLICK, edge_n + 1 + T_GAP);
    drive(1'b1, 20);
    check("t1_evt_cnt", int'(evt_cnt), 1);

    // Double click
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 4);
    expect_evt(K_DBL, edge_n + 1);
    drive(1'b1, 12);
    check("t2_evt_cnt", int'(evt_cnt), 2);

    // Long press with held level
    expect_evt(K_LONG, edge_n + 1 + T_LONG);
    drive(1'b0, 25);
    check("t3_held_hi", int'(held), 1);
    drive(1'b0, 5);
    check("t3_held_still", int'(held), 1);
    drive(1'b1, 1);
    check("t3_held_lo", int'(held), 0);
    drive(1'b1, 12);
    check("t3_evt_cnt", int'(evt_cnt), 3);

    // Release coincident with the long threshold: release wins
    drive(1'b0, T_LONG);
    expect_evt(K_CLICK, edge_n + 1 + T_GAP);
    drive(1'b1, 12);
    check("t4a_evt_cnt", int'(evt_cnt), 4);

    // Second press coincident with gap timeout: press wins
    drive(1'b0, 5);
    drive(1'b1, T_GAP);
    drive(1'b0, 3);
    expect_evt(K_DBL, edge_n + 1);
    drive(1'b1, 12);
    check("t4b_evt_cnt", int'(evt_cnt), 5);

    // Key held through reset deassertion produces nothing
    key_n = 1'b0;
    rst   = 1'b1;
    drive(1'b0, 3);
    rst = 1'b0;
    drive(1'b0, 40);
    check_quiet("t5_held_through");
    drive(1'b1, 3);
    drive(1'b0, 5);
    expect_evt(K_CLICK, edge_n + 1 + T_GAP);
    drive(1'b1, 10);
    check("t5_evt_cnt", int'(evt_cnt), 1);

    // 256 back-to-back clicks, next press right after each strobe
    rst = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    drive(1'b1, 2);
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 2);
      expect_evt(K_CLICK, edge_n + 1 + T_GAP);
      drive(1'b1, T_GAP + 1);
      if (i == 254) check("t6_evt_255", int'(evt_cnt), 255);
    end
    check("t6_evt_wrap", int'(evt_cnt), 0);

    // Reset during WAIT2 drops the pending click
    drive(1'b0, 3);
    drive(1'b1, 4);
    rst = 1'b1;
    #1;
    check_quiet("t6_rst_async");
    drive(1'b1, 12);
    rst = 1'b0;
    drive(1'b1, 12);
    check_quiet("t6_after_rst");
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
